// File: rtl/if_id_buffer.sv
// Two-entry elastic IF/ID buffer: head register feeds decode, skid register absorbs one
// cycle of back-pressure. Flush empties the buffer; MIPS fields are sliced from the head.
module if_id_buffer #(
    parameter int unsigned PC_WIDTH    = 32,
    parameter int unsigned INSTR_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   if_valid,
    output logic                   if_ready,
    input  logic [PC_WIDTH-1:0]    if_pc,
    input  logic [INSTR_WIDTH-1:0] if_instr,
    input  logic                   flush,
    output logic                   id_valid,
    input  logic                   id_ready,
    output logic [PC_WIDTH-1:0]    id_pc,
    output logic [INSTR_WIDTH-1:0] id_instr,
    output logic [5:0]             id_opcode,
    output logic [4:0]             id_rs,
    output logic [4:0]             id_rt,
    output logic [4:0]             id_rd,
    output logic [15:0]            id_imm,
    output logic [1:0]             occupancy
);

    typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

    state_e                 state_q, state_d;
    logic [PC_WIDTH-1:0]    head_pc_q, head_pc_d, skid_pc_q, skid_pc_d;
    logic [INSTR_WIDTH-1:0] head_instr_q, head_instr_d, skid_instr_q, skid_instr_d;
    logic                   accept, consume;

    // Handshake outputs come only from registered state: no combinational ready/valid paths.
    assign if_ready = (state_q != StTwo);
    assign id_valid = (state_q != StEmpty);
    assign accept   = if_valid && if_ready;
    assign consume  = id_valid && id_ready;

    always_comb begin
        state_d      = state_q;
        head_pc_d    = head_pc_q;
        head_instr_d = head_instr_q;
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;
        if (flush) begin
            // Registers hold stale contents; a word accepted this cycle is dropped.
            state_d = StEmpty;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (accept) begin
                        head_pc_d    = if_pc;
                        head_instr_d = if_instr;
                        state_d      = StOne;
                    end
                end
                StOne: begin
                    if (accept && consume) begin
                        head_pc_d    = if_pc;
                        head_instr_d = if_instr;
                    end else if (accept) begin
                        skid_pc_d    = if_pc;
                        skid_instr_d = if_instr;
                        state_d      = StTwo;
                    end else if (consume) begin
                        state_d = StEmpty;
                    end
                end
                StTwo: begin
                    if (consume) begin
                        head_pc_d    = skid_pc_q;
                        head_instr_d = skid_instr_q;
                        state_d      = StOne;
                    end
                end
                default: state_d = StEmpty;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StEmpty;
            head_pc_q    <= '0;
            head_instr_q <= '0;
            skid_pc_q    <= '0;
            skid_instr_q <= '0;
        end else begin
            state_q      <= state_d;
            head_pc_q    <= head_pc_d;
            head_instr_q <= head_instr_d;
            skid_pc_q    <= skid_pc_d;
            skid_instr_q <= skid_instr_d;
        end
    end

    always_comb begin
        occupancy = 2'd0;
        unique case (state_q)
            StOne:   occupancy = 2'd1;
            StTwo:   occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

    assign id_pc     = head_pc_q;
    assign id_instr  = head_instr_q;
    assign id_opcode = head_instr_q[31:26];
    assign id_rs     = head_instr_q[25:21];
    assign id_rt     = head_instr_q[20:16];
    assign id_rd     = head_instr_q[15:11];
    assign id_imm    = head_instr_q[15:0];

endmodule

// File: doc/if_id_buffer.md
# if_id_buffer

Two-entry elastic pipeline buffer between the instruction fetch stage and the decode stage. It captures each fetched instruction word and its PC, then presents them to decode with a valid/ready handshake. It absorbs one cycle of decode back-pressure without losing a fetched word, and it discards in-flight words on a flush from branch/jump resolution. It also slices the MIPS-style register and immediate fields out of the held instruction for the decode logic.

## Interface
- PC_WIDTH, 32, width of the program counter carried with each instruction
- INSTR_WIDTH, 32, instruction word width; the field slicing below requires 32
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- if_valid  in  1  fetch presents a valid word this cycle
- if_ready  out  1  buffer can accept a word this cycle
- if_pc  in  PC_WIDTH  PC of the presented word
- if_instr  in  INSTR_WIDTH  presented instruction word
- flush  in  1  discard all held words; has priority over all other activity
- id_valid  out  1  id_* outputs hold a valid instruction
- id_ready  in  1  decode consumes the word this cycle
- id_pc  out  PC_WIDTH  PC of the head word
- id_instr  out  INSTR_WIDTH  head instruction word
- id_opcode  out  6  id_instr[31:26]
- id_rs  out  5  id_instr[25:21]
- id_rt  out  5  id_instr[20:16]
- id_rd  out  5  id_instr[15:11]
- id_imm  out  16  id_instr[15:0]
- occupancy  out  2  number of held words, 0 to 2

## Operation
- Storage: a head register (drives id_*) and a skid register. Order is strict FIFO.
- Accept = if_valid && if_ready. Consume = id_valid && id_ready.
- States: EMPTY (occupancy 0), ONE (head valid), TWO (head and skid valid).
- EMPTY: on accept, load head and go to ONE.
- ONE: accept only, load skid and go to TWO. Consume only, go to EMPTY. Accept and consume together, load head with the input and stay in ONE.
- TWO: consume moves skid to head and goes to ONE. No accept is possible in TWO.
- if_ready = (state != TWO). It depends only on registered state, so there is no combinational path from id_ready or if_valid.
- id_valid = (state != EMPTY), also derived from registered state only.
- Flush: the next state is EMPTY regardless of accept or consume in the same cycle. A word accepted in the flush cycle is dropped. A word consumed in the flush cycle counts as delivered, because decode has already sampled it.
- Field outputs are combinational slices of the head register.
- Holding rule: when no update occurs, the head and skid registers keep their values. After a consume or flush, id_pc and id_instr keep their stale contents with id_valid=0.

## Timing
- Reset values: state EMPTY, id_valid=0, if_ready=1, occupancy=0, and id_pc, id_instr and all fields at 0. Reset also clears the skid register to 0.
- Reset asserted mid-transfer takes effect asynchronously. The words being transferred are lost and no partial update survives.
- Latency: a word accepted at edge N has id_valid=1 and the word on id_* after edge N; at the earliest it can be consumed in cycle N+1.
- Throughput: one word per cycle sustained while id_ready stays high.
- Back-pressure: after id_ready drops, the buffer takes at most one more word and then drops if_ready.
- Flush response: id_valid=0 and if_ready=1 in the cycle after the flush edge.

## Test plan
- Reset and pass-through:
  - Stimulus: release reset, then feed PC 0,1,2 with instructions 0x8C010004, 0x00221820, 0x1000FFFF, with id_ready=1.
  - Required response: id_valid rises one cycle after each accept. For 0x8C010004 the fields show id_opcode=0x23, id_rs=0, id_rt=1, id_imm=0x0004, and the order is preserved.
- Back-pressure:
  - Stimulus: stream PCs 10 to 15 with id_ready held 0 for 3 cycles.
  - Required response: occupancy reaches 2 and if_ready=0 while full. When id_ready returns to 1, all six words emerge in order with none duplicated or lost.
- Simultaneous accept and consume in ONE:
  - Stimulus: occupancy=1, then if_valid=1 and id_ready=1 together.
  - Required response: occupancy stays 1 and the head becomes the new word.
- Flush while full:
  - Stimulus: occupancy=2 and if_valid=1 when flush=1 is asserted.
  - Required response: next cycle occupancy=0, id_valid=0, if_ready=1. The next accepted word (PC 0x40) appears as the head.
- Mid-stream reset:
  - Stimulus: assert reset asynchronously between edges while occupancy=2.
  - Required response: immediately id_valid=0, occupancy=0, id_instr=0, if_ready=1.
